insn_encoder: RTL
=================

// Module: insn_encoder
// PURPOSE
//  Turns field-level instruction requests (op, rd, rs1, rs2, imm) into 32-bit
//  RV32I words and writes them sequentially into instruction memory.
//  It is the encode end of the core's instruction format and is used by the
//  program loader and self-test to build programs in imem.
//  It covers the op subset the core decodes: BEQ JALR JAL LUI AUIPC ADDI LB SB.
// PARAMETERS
//  AW  32  imem byte-address width; the address steps by 4 per word
// PORTS
//  clk         in   1   clock
//  reset_n     in   1   asynchronous active-low reset
//  start       in   1   pulse: begin a load session at start_addr (ignored unless IDLE)
//  start_addr  in   AW  first word address, word aligned
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid && req_ready
//  req_op      in   4   0 BEQ,1 JALR,2 JAL,3 LUI,4 AUIPC,5 ADDI,6 LB,7 SB; 8-15 illegal
//  req_rd/req_rs1/req_rs2  in 5 each  register fields
//  req_imm     in   32  byte immediate, two's complement
//  req_last    in   1   final request of the session
//  imem_we     out  1   write request; held until imem_ready
//  imem_addr   out  AW  write address
//  imem_wdata  out  32  encoded word
//  imem_ready  in   1   memory accepts the write this cycle
//  busy        out  1   state != IDLE
//  done        out  1   one-cycle pulse at session end
//  err         out  1   sticky; set by an illegal op or out-of-range imm; cleared by start
//  word_count  out  AW  words written in the current session
// BEHAVIOUR
//  Reset: state IDLE. All outputs are 0; imem_addr and word_count are 0.
//  FSM: IDLE -start-> LOAD -(last request retired)-> DONE -> IDLE.
//   DONE lasts 1 cycle; done=1 only in DONE.
//  On start: load the address register from start_addr, clear err and word_count.
//  req_ready = (state==LOAD) && !last_seen && (!imem_we || imem_ready).
//   This gives one output register with pass-through. Full throughput is 1 word/cycle.
//  Latency: a request accepted at edge N drives imem_we=1 with its word from
//   cycle N+1. imem_we stays asserted with a stable addr/data until imem_ready=1.
//  Write handshake (imem_we && imem_ready): address += 4, word_count += 1.
//   The address wraps modulo 2^AW with no flag.
//  Encoding, with standard RV32I field placement:
//   BEQ  B-type opc 1100011 f3 000 | JALR I-type opc 1100111 f3 000
//   JAL  J-type opc 1101111        | LUI/AUIPC U-type opc 0110111/0010111
//   ADDI I-type opc 0010011 f3 000 | LB I-type opc 0000011 f3 000
//   SB   S-type opc 0100011 f3 000
//  Unused register fields are encoded as 0 (for example, rs2 for I-type).
//  Range checks; a violation sets err:
//   I/S: imm[31:11] all equal.
//   B: imm[31:12] all equal and imm[0]==0.
//   J: imm[31:20] all equal and imm[0]==0.
//   U: imm[11:0]==0.
//  Illegal op or bad imm: the request is still consumed. No write occurs, and
//   address and word_count are unchanged. If req_last is set, the session still ends.
//  Session end: after req_last is accepted, no further requests are taken.
//   Go to DONE once no write is pending (imem_we==0, or its handshake this cycle).
//  start while busy: ignored. req_valid in IDLE: ignored, req_ready=0.
//  Reset mid-session: immediate return to IDLE. A pending write is dropped;
//   words already written stay in memory.
// TESTING
//  ADDI rd=1 rs1=0 imm=5, start_addr=0x100, imem_ready=1
//   -> imem_wdata=0x00500093 at 0x100 one cycle after accept.
//  LUI rd=2 imm=0x12345000; SB rs1=1 rs2=3 imm=4; BEQ rs1=1 rs2=2 imm=8 (last)
//   -> 0x12345137, 0x00308223, 0x00208463 at consecutive addresses,
//   then done pulse, word_count=3.
//  JAL rd=1 imm=0x800 with imem_ready low 3 cycles
//   -> 0x001000EF held stable, req_ready=0 while stalled, accepted on 4th cycle.
//  ADDI imm=0x800, op=9, BEQ imm=3
//   -> err=1, no writes, address unchanged; next start clears err.
//  Back-to-back 16 ADDIs with imem_ready=1
//   -> one write per cycle, addresses +4, word_count=16.
//  Drop reset_n mid-stall
//   -> imem_we=0, busy=0, req_ready=0 immediately.

Source files
------------

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: turns field-level requests into 32-bit words and
// streams them into instruction memory through a single pass-through output register.
module insn_encoder #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [31:0]   req_imm,
    input  logic          req_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic          imem_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] word_count
);

    localparam logic [3:0] OP_BEQ   = 4'd0;
    localparam logic [3:0] OP_JALR  = 4'd1;
    localparam logic [3:0] OP_JAL   = 4'd2;
    localparam logic [3:0] OP_LUI   = 4'd3;
    localparam logic [3:0] OP_AUIPC = 4'd4;
    localparam logic [3:0] OP_ADDI  = 4'd5;
    localparam logic [3:0] OP_LB    = 4'd6;
    localparam logic [3:0] OP_SB    = 4'd7;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [2:0] F3_ZERO    = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] encode_word(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (op)
            OP_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, F3_ZERO, imm[4:1], imm[11], OPC_BRANCH};
            OP_JALR:  w = {imm[11:0], rs1, F3_ZERO, rd, OPC_JALR};
            OP_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            OP_LUI:   w = {imm[31:12], rd, OPC_LUI};
            OP_AUIPC: w = {imm[31:12], rd, OPC_AUIPC};
            OP_ADDI:  w = {imm[11:0], rs1, F3_ZERO, rd, OPC_OPIMM};
            OP_LB:    w = {imm[11:0], rs1, F3_ZERO, rd, OPC_LOAD};
            OP_SB:    w = {imm[11:5], rs2, rs1, F3_ZERO, imm[4:0], OPC_STORE};
            default:  w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // An immediate is encodable when the bits dropped by the format are pure sign extension.
    function automatic logic request_legal(input logic [3:0] op, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_BEQ:                    ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            OP_JAL:                    ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            OP_LUI, OP_AUIPC:          ok = !(|imm[11:0]);
            OP_JALR, OP_ADDI, OP_LB,
            OP_SB:                     ok = (&imm[31:11]) || !(|imm[31:11]);
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t        state_r;
    state_t        state_n;
    logic          last_seen_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [AW-1:0] count_r;
    logic          err_r;
    logic          busy_r;
    logic          done_r;

    logic          req_ready_s;
    logic          accept_s;
    logic          write_hs_s;
    logic          start_s;
    logic [31:0]   enc_word_s;
    logic          req_legal_s;

    assign req_ready_s = (state_r == ST_LOAD) && !last_seen_r && (!we_r || imem_ready);
    assign accept_s    = req_valid && req_ready_s;
    assign write_hs_s  = we_r && imem_ready;
    assign start_s     = start && (state_r == ST_IDLE);

    // Encode and range-check the request currently on the input fields.
    always_comb begin
        enc_word_s  = encode_word(req_op, req_rd, req_rs1, req_rs2, req_imm);
        req_legal_s = request_legal(req_op, req_imm);
    end

    // Session state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic: leave LOAD only once the last request's write has drained.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_seen_r && (!we_r || imem_ready)) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_LOAD;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output register, address/count tracking and sticky error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_seen_r <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= 32'h0000_0000;
            count_r     <= {AW{1'b0}};
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_n != ST_IDLE);
            done_r <= (state_n == ST_DONE);
            if (start_s) begin
                addr_r      <= start_addr;
                count_r     <= {AW{1'b0}};
                err_r       <= 1'b0;
                last_seen_r <= 1'b0;
            end else begin
                if (write_hs_s) begin
                    addr_r  <= addr_r + AW'(4);
                    count_r <= count_r + AW'(1);
                end
                if (accept_s && req_last) begin
                    last_seen_r <= 1'b1;
                end
                if (accept_s && !req_legal_s) begin
                    err_r <= 1'b1;
                end
            end
            // A rejected request is consumed without touching the output register.
            if (accept_s && req_legal_s) begin
                we_r    <= 1'b1;
                wdata_r <= enc_word_s;
            end else if (write_hs_s) begin
                we_r <= 1'b0;
            end
        end
    end

    assign req_ready  = req_ready_s;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign word_count = count_r;

endmodule
